// File: rtl/seg7_if.sv
// Display-word bus between the calculator datapath and the 7-segment scanner.
// The master supplies the word and load strobe; the slave drives the pins.
interface seg7_if;
    logic [15:0] bcd_in;
    logic        neg_in;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;

    modport master (
        output bcd_in, neg_in, load,
        input  an, seg, dp, digit_idx
    );

    modport slave (
        input  bcd_in, neg_in, load,
        output an, seg, dp, digit_idx
    );
endinterface

// File: rtl/seg7_scan.sv
// Four-digit 7-segment scanner: shadows the display word, then multiplexes it with
// leading-zero blanking, minus-sign placement and dark gaps between digits.
module seg7_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYCLES  = 16,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic  clk,
    input  logic  resetn,
    seg7_if.slave bus
);
    localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0] AN_POL  = {4{ACTIVE_LOW}};
    localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};
    localparam logic       DP_POL  = ACTIVE_LOW;

    typedef enum logic {ST_SHOW, ST_GAP} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       idx_reg, idx_next;
    logic [15:0]      shadow_reg;
    logic             neg_reg;

    logic [3:0]       an_reg;
    logic [6:0]       seg_reg;
    logic             dp_reg;
    logic [1:0]       idx_out_reg;

    logic [3:0][3:0]  nib;
    logic [3:0]       nz;
    logic [3:0]       blank;
    logic [3:0]       minus_at;

    logic [3:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;

    // Segment patterns, active-high {g,f,e,d,c,b,a}; E renders as '-', F as blank.
    function automatic logic [6:0] font(input logic [3:0] value);
        case (value)
            4'h0: font = 7'h3F;
            4'h1: font = 7'h06;
            4'h2: font = 7'h5B;
            4'h3: font = 7'h4F;
            4'h4: font = 7'h66;
            4'h5: font = 7'h6D;
            4'h6: font = 7'h7D;
            4'h7: font = 7'h07;
            4'h8: font = 7'h7F;
            4'h9: font = 7'h6F;
            4'hA: font = 7'h77;
            4'hB: font = 7'h7C;
            4'hC: font = 7'h39;
            4'hD: font = 7'h5E;
            4'hE: font = 7'h40;
            default: font = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= ST_GAP;
            cnt_reg    <= '0;
            idx_reg    <= 2'd0;
            shadow_reg <= 16'h0000;
            neg_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            if (bus.load) begin
                shadow_reg <= bus.bcd_in;
                neg_reg    <= bus.neg_in;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        idx_next   = idx_reg;
        case (state_reg)
            ST_SHOW: begin
                if (cnt_reg == SHOW_LAST) begin
                    state_next = ST_GAP;
                    cnt_next   = '0;
                end
            end
            default: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = ST_SHOW;
                    cnt_next   = '0;
                    idx_next   = idx_reg + 2'd1;
                end
            end
        endcase
    end

    // A digit is blank when it and every digit to its left hold zero; the minus sign
    // lands on the blank digit sitting just left of the leftmost visible one.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign nib[gi] = shadow_reg[gi*4 +: 4];
        assign nz[gi]  = |shadow_reg[gi*4 +: 4];
        if (gi == 0) begin : g_lsd
            assign blank[gi]    = 1'b0;
            assign minus_at[gi] = 1'b0;
        end else begin : g_upper
            assign blank[gi]    = ~(|nz[3:gi]);
            assign minus_at[gi] = neg_reg & blank[gi] & ~blank[gi-1];
        end
    end

    always_comb begin
        an_next  = 4'b0000;
        seg_next = 7'h00;
        dp_next  = 1'b0;
        if (state_reg == ST_SHOW) begin
            an_next = 4'b0001 << idx_reg;
            if (minus_at[idx_reg]) begin
                seg_next = 7'h40;
            end else if (!blank[idx_reg]) begin
                seg_next = font(nib[idx_reg]);
            end
            // No blank slot left for the sign: fall back to the leftmost decimal point.
            dp_next = (idx_reg == 2'd3) & neg_reg & nz[3];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            an_reg      <= AN_POL;
            seg_reg     <= SEG_POL;
            dp_reg      <= DP_POL;
            idx_out_reg <= 2'd0;
        end else begin
            an_reg      <= an_next ^ AN_POL;
            seg_reg     <= seg_next ^ SEG_POL;
            dp_reg      <= dp_next ^ DP_POL;
            idx_out_reg <= idx_reg;
        end
    end

    assign bus.an        = an_reg;
    assign bus.seg       = seg_reg;
    assign bus.dp        = dp_reg;
    assign bus.digit_idx = idx_out_reg;
endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan (REFRESH_DIV=4, GAP_CYCLES=1, active-low): a time-slot model of the
// scan plus a word-level renderer predict every output cycle; vectors and corner sequences on top.
module tb_seg7_scan;
    localparam int REFRESH = 4;
    localparam int GAP     = 1;
    localparam int PERIOD  = REFRESH + GAP;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    seg7_if bus ();

    seg7_scan #(
        .REFRESH_DIV(REFRESH),
        .GAP_CYCLES (GAP),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          k;
    logic [15:0] m_word;
    logic        m_neg;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [1:0]  e_idx;
    bit          e_idx_valid;
    logic [6:0]  font [16];

    typedef struct {
        logic [15:0] word;
        logic        neg;
        int          digit;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Renders one digit of a word straight from the display rules (active-low result).
    function automatic void render(input logic [15:0] w, input logic ng, input int d,
                                   output logic [6:0] s, output logic p);
        int lead;
        logic [6:0] h;
        lead = 0;
        for (int i = 0; i < 4; i++)
            if (w[i*4 +: 4] != 4'h0) lead = i;
        if (d > lead) h = (ng && d == lead + 1) ? 7'h40 : 7'h00;
        else          h = font[w[d*4 +: 4]];
        s = ~h;
        p = ~(ng && lead == 3 && d == 3);
    endfunction

    // One clock: predict the outputs produced by this edge, then compare at the falling edge.
    task automatic cycle();
        int m, slot, ph, d;
        @(posedge clk);
        if (!resetn) begin
            k = 0; m_word = 16'h0; m_neg = 1'b0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_idx = 2'd0; e_idx_valid = 1'b1;
        end else begin
            k++;
            m = k - 1; slot = m / PERIOD; ph = m % PERIOD;
            if (ph < GAP) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_idx_valid = 1'b0;
            end else begin
                d = (slot + 1) % 4;
                e_an = ~(4'b0001 << d);
                render(m_word, m_neg, d, e_seg, e_dp);
                e_idx = d[1:0];
                e_idx_valid = 1'b1;
            end
            if (bus.load) begin
                m_word = bus.bcd_in;
                m_neg  = bus.neg_in;
            end
        end
        @(negedge clk);
        chk("outputs", {20'h0, bus.an, bus.seg, bus.dp}, {20'h0, e_an, e_seg, e_dp});
        if (e_idx_valid) chk("digit_idx", {30'h0, bus.digit_idx}, {30'h0, e_idx});
    endtask

    task automatic wait_an(input logic [3:0] want, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.an === want) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: an stuck at %h, wanted %h", name, bus.an, want);
        end
    endtask

    // Waits for the first SHOW cycle of digit d.
    task automatic wait_digit(input int d, input string name);
        logic [3:0] want;
        want = ~(4'b0001 << d);
        wait_an(4'hF, name);
        wait_an(want, name);
    endtask

    task automatic do_load(input logic [15:0] w, input logic n);
        bus.bcd_in = w;
        bus.neg_in = n;
        bus.load   = 1'b1;
        cycle();
        bus.load   = 1'b0;
    endtask

    initial begin
        int order [5];
        logic [3:0] exp_an;
        logic [15:0] w;
        int nzd;

        font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h40, 7'h00};
        order = '{1, 2, 3, 0, 1};
        vecs = '{
            '{16'h1234, 1'b0, 0, 7'h19, 1'b1},
            '{16'h1234, 1'b0, 3, 7'h79, 1'b1},
            '{16'h1234, 1'b0, 1, 7'h30, 1'b1},
            '{16'h0007, 1'b0, 3, 7'h7F, 1'b1},
            '{16'h0007, 1'b0, 1, 7'h7F, 1'b1},
            '{16'h0007, 1'b0, 0, 7'h78, 1'b1},
            '{16'h0042, 1'b1, 2, 7'h3F, 1'b1},
            '{16'h0042, 1'b1, 3, 7'h7F, 1'b1},
            '{16'h0042, 1'b1, 1, 7'h19, 1'b1},
            '{16'h9876, 1'b1, 3, 7'h10, 1'b0},
            '{16'h9876, 1'b1, 2, 7'h00, 1'b1},
            '{16'h0A0B, 1'b0, 2, 7'h08, 1'b1},
            '{16'h0A0B, 1'b0, 0, 7'h03, 1'b1},
            '{16'h0F0E, 1'b0, 2, 7'h7F, 1'b1},
            '{16'h0F0E, 1'b0, 0, 7'h3F, 1'b1},
            '{16'h0000, 1'b0, 0, 7'h40, 1'b1},
            '{16'h0000, 1'b0, 1, 7'h7F, 1'b1},
            '{16'h0000, 1'b1, 1, 7'h3F, 1'b1}
        };

        bus.bcd_in = 16'h0;
        bus.neg_in = 1'b0;
        bus.load   = 1'b0;

        // Reset held for three cycles, then the scan order from the first GAP.
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("reset_pins", {20'h0, bus.an, bus.seg, bus.dp}, {20'h0, 4'hF, 7'h7F, 1'b1});
        chk("reset_idx", {30'h0, bus.digit_idx}, 32'd0);
        resetn = 1'b1;
        cycle();
        chk("first_gap", {28'h0, bus.an}, 32'hF);
        for (int j = 0; j < 5; j++) begin
            for (int c = 0; c < PERIOD; c++) begin
                cycle();
                exp_an = (c < REFRESH) ? ~(4'b0001 << order[j]) : 4'hF;
                chk("scan_order", {28'h0, bus.an}, {28'h0, exp_an});
            end
        end
        $display("scan order 1,2,3,0,1 walked");

        // Table of display words and the segment pattern each digit must show.
        foreach (vecs[i]) begin
            do_load(vecs[i].word, vecs[i].neg);
            wait_digit(vecs[i].digit, "vec_wait");
            chk("vec_seg", {25'h0, bus.seg}, {25'h0, vecs[i].seg});
            chk("vec_dp", {31'h0, bus.dp}, {31'h0, vecs[i].dp});
            $display("vec %0d word=%h neg=%b digit=%0d seg=%h dp=%b",
                     i, vecs[i].word, vecs[i].neg, vecs[i].digit, bus.seg, bus.dp);
        end

        // Load during digit-0 SHOW: old value for one more cycle, new value on the second.
        do_load(16'h0001, 1'b0);
        wait_digit(0, "load_wait");
        chk("load_pre", {25'h0, bus.seg}, {25'h0, 7'h79});
        bus.bcd_in = 16'h0008;
        bus.load   = 1'b1;
        cycle();
        bus.load   = 1'b0;
        chk("load_plus1", {25'h0, bus.seg}, {25'h0, 7'h79});
        cycle();
        chk("load_plus2", {25'h0, bus.seg}, {25'h0, 7'h00});
        $display("load during SHOW: seg updated two cycles after strobe");

        // Reset in the middle of digit 2 SHOW, then input churn with no load strobe.
        do_load(16'h5678, 1'b0);
        wait_digit(2, "midreset_wait");
        cycle();
        resetn = 1'b0;
        cycle();
        chk("midreset_pins", {20'h0, bus.an, bus.seg, bus.dp}, {20'h0, 4'hF, 7'h7F, 1'b1});
        resetn = 1'b1;
        bus.bcd_in = 16'hABCD;
        bus.neg_in = 1'b1;
        wait_digit(0, "noload_wait0");
        chk("noload_d0", {25'h0, bus.seg}, {25'h0, 7'h40});
        wait_digit(1, "noload_wait1");
        chk("noload_d1", {25'h0, bus.seg}, {25'h0, 7'h7F});
        $display("mid-scan reset cleared the shadow word");

        // Random words (biased to short values), random strobes and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            nzd = $urandom_range(0, 4);
            w   = 16'($urandom) & 16'((32'd1 << (4 * nzd)) - 1);
            bus.bcd_in = w;
            bus.neg_in = 1'($urandom_range(0, 1));
            bus.load   = ($urandom_range(0, 5) == 0);
            resetn     = ($urandom_range(0, 249) != 0);
            cycle();
        end
        bus.load = 1'b0;
        resetn   = 1'b1;
        cycle();
        $display("random phase done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
